// File: rtl/regfile_read_stage.sv
// regfile_read_stage
//
// Registered dual read port for the 32-entry register file. It selects two
// source operands from the register file's outputs and applies same-cycle
// write bypass from the write port. The result sits in a single pipeline
// slot with a valid/ready handshake. While that slot is stalled, later
// writes keep the held pair in step with the register file contents.
//
// Ports
//   clk, reset            : single clock; synchronous active-high reset
//   Q_all                 : concatenated register outputs, register i at [i*WIDTH +: WIDTH]
//   RegWriteI, CP_o, Rd   : register file write port (global enable, one-hot select, data)
//   in_valid, in_ready    : request handshake
//   rs_addr, rt_addr      : source register indices
//   out_valid, out_ready  : operand pair handshake
//   rs_data, rt_data      : registered operands
//   rs_idx, rt_idx        : registered copies of the accepted indices
//
// Configuration
//   REGREAD_ZERO_R0_EN    : when defined, register 0 always reads as zero and is
//                           never bypassed or stall-updated.
//
// State table
//   state | meaning
//   EMPTY | slot holds nothing, out_valid = 0
//   FULL  | slot holds an operand pair, out_valid = 1

module regfile_read_stage #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [32*WIDTH-1:0] Q_all,
    input  logic                RegWriteI,
    input  logic [31:0]         CP_o,
    input  logic [WIDTH-1:0]    Rd,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    rs_data,
    output logic [WIDTH-1:0]    rt_data,
    output logic [4:0]          rs_idx,
    output logic [4:0]          rt_idx
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [31:0]      hit_vec;
    logic [WIDTH-1:0] rs_sel;
    logic [WIDTH-1:0] rt_sel;

    // Per-register write hit. CP_o is used bit by bit, with no decode and
    // no one-hot check.
    always_comb begin
        hit_vec = RegWriteI ? CP_o : 32'd0;
`ifdef REGREAD_ZERO_R0_EN
        hit_vec[0] = 1'b0;
`endif
    end

    always_comb begin
        rs_sel = hit_vec[rs_addr] ? Rd : Q_all[rs_addr*WIDTH +: WIDTH];
        rt_sel = hit_vec[rt_addr] ? Rd : Q_all[rt_addr*WIDTH +: WIDTH];
`ifdef REGREAD_ZERO_R0_EN
        if (rs_addr == 5'd0) rs_sel = '0;
        if (rt_addr == 5'd0) rt_sel = '0;
`endif
    end

    // A full slot can drain and refill in the same cycle, so readiness
    // depends only on the output side.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_data <= '0;
            rt_data <= '0;
            rs_idx  <= '0;
            rt_idx  <= '0;
        end else if (accept) begin
            rs_data <= rs_sel;
            rt_data <= rt_sel;
            rs_idx  <= rs_addr;
            rt_idx  <= rt_addr;
        end else if (out_valid && !out_ready) begin
            // A stalled pair tracks writes to its registers. hit_vec already
            // excludes register 0 when that register is hardwired to zero.
            if (hit_vec[rs_idx]) rs_data <= Rd;
            if (hit_vec[rt_idx]) rt_data <= Rd;
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
module tb_regfile_read_stage;

    localparam int WIDTH = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [32*WIDTH-1:0] Q_all;
    logic                RegWriteI;
    logic [31:0]         CP_o;
    logic [WIDTH-1:0]    Rd;
    logic                in_valid;
    logic                in_ready;
    logic [4:0]          rs_addr;
    logic [4:0]          rt_addr;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    rs_data;
    logic [WIDTH-1:0]    rt_data;
    logic [4:0]          rs_idx;
    logic [4:0]          rt_idx;

    always #5 clk = ~clk;

    regfile_read_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .Q_all(Q_all), .RegWriteI(RegWriteI),
        .CP_o(CP_o), .Rd(Rd), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .out_valid(out_valid),
        .out_ready(out_ready), .rs_data(rs_data), .rt_data(rt_data),
        .rs_idx(rs_idx), .rt_idx(rt_idx)
    );

    typedef struct packed {
        logic [WIDTH-1:0] rs_d;
        logic [WIDTH-1:0] rt_d;
        logic [4:0]       rs_i;
        logic [4:0]       rt_i;
    } pair_t;

    pair_t sb[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    logic  pre_in_ready;

`ifdef REGREAD_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    function automatic logic m_hit(input logic [4:0] a);
        if (ZERO_R0 && a == 5'd0) return 1'b0;
        return RegWriteI & CP_o[a];
    endfunction

    function automatic logic [WIDTH-1:0] m_sel(input logic [4:0] a);
        if (ZERO_R0 && a == 5'd0) return '0;
        if (m_hit(a)) return Rd;
        return Q_all[a*WIDTH +: WIDTH];
    endfunction

    // Drives one cycle of stimulus, then advances the scoreboard at the edge:
    // pop on drain, update on stall-write, push on accept.
    task automatic cycle(input logic iv, input logic [4:0] ra, input logic [4:0] rb,
                         input logic ordy, input logic rwi, input logic [31:0] cp,
                         input logic [WIDTH-1:0] rd, input logic rst);
        bit    m_full;
        bit    m_acc;
        pair_t np;
        @(negedge clk);
        in_valid = iv; rs_addr = ra; rt_addr = rb; out_ready = ordy;
        RegWriteI = rwi; CP_o = cp; Rd = rd; reset = rst;
        #1;
        pre_in_ready = in_ready;
        m_full = (sb.size() != 0);
        m_acc  = iv && (!m_full || ordy);
        np = '{rs_d: m_sel(ra), rt_d: m_sel(rb), rs_i: ra, rt_i: rb};
        if (rst) begin
            sb.delete();
        end else begin
            if (m_full && !ordy) begin
                if (m_hit(sb[0].rs_i)) sb[0].rs_d = rd;
                if (m_hit(sb[0].rt_i)) sb[0].rt_d = rd;
            end
            if (m_full && ordy) void'(sb.pop_front());
            if (m_acc) sb.push_back(np);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 5'd4, 5'd5, 1'b1, 1'b0, 32'd0, '0, 1'b1);
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_idx, rt_idx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%0b rs=%h rt=%h ri=%0d ti=%0d, want all 0",
                     out_valid, rs_data, rt_data, rs_idx, rt_idx);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_read();
        cycle(1'b1, 5'd3, 5'd31, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_idx, rt_idx} !==
            {1'b1, 32'h33, 32'h20F, 5'd3, 5'd31}) begin
            tests_failed++;
            $display("FAIL basic_read: got v=%0b rs=%h rt=%h ri=%0d ti=%0d, want 1 33 20f 3 31",
                     out_valid, rs_data, rt_data, rs_idx, rt_idx);
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        cycle(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, 32'hDEADBEEF, 32'h66}) begin
            tests_failed++;
            $display("FAIL bypass_hit: got v=%0b rs=%h rt=%h, want 1 deadbeef 66",
                     out_valid, rs_data, rt_data);
        end
        cycle(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, 32'h55, 32'h66}) begin
            tests_failed++;
            $display("FAIL bypass_nohit: got v=%0b rs=%h rt=%h, want 1 55 66",
                     out_valid, rs_data, rt_data);
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, '0, 1'b0);
    endtask

    task automatic test_stall();
        cycle(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, 32'h77, 32'h77}) begin
            tests_failed++;
            $display("FAIL stall_capture: got v=%0b rs=%h rt=%h, want 1 77 77",
                     out_valid, rs_data, rt_data);
        end
        cycle(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 32'h80, 32'h1234, 1'b0);
        tests_run++;
        if (pre_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_in_ready: got %b want 0", pre_in_ready);
        end
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_idx, rt_idx} !==
            {1'b1, 32'h1234, 32'h1234, 5'd7, 5'd7}) begin
            tests_failed++;
            $display("FAIL stall_update: got v=%0b rs=%h rt=%h ri=%0d ti=%0d, want 1 1234 1234 7 7",
                     out_valid, rs_data, rt_data, rs_idx, rt_idx);
        end
        // A write to an unrelated register must leave the held pair alone.
        cycle(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 32'h100, 32'h5555, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_idx, rt_idx} !==
            {1'b1, 32'h1234, 32'h1234, 5'd7, 5'd7}) begin
            tests_failed++;
            $display("FAIL stall_hold: got v=%0b rs=%h rt=%h ri=%0d ti=%0d, want 1 1234 1234 7 7",
                     out_valid, rs_data, rt_data, rs_idx, rt_idx);
        end
        tests_run++;
        if (sb.size() != 1 || {rs_data, rt_data} !== {sb[0].rs_d, sb[0].rt_d}) begin
            tests_failed++;
            $display("FAIL stall_scoreboard: got rs=%h rt=%h, scoreboard depth %0d",
                     rs_data, rt_data, sb.size());
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 5'(i), 5'(7 - i), 1'b1, 1'b0, 32'd0, '0, 1'b0);
            tests_run++;
            if (pre_in_ready !== 1'b1 || out_valid !== 1'b1 ||
                {rs_data, rt_data, rs_idx, rt_idx} !==
                {32'(i * 32'h11), 32'((7 - i) * 32'h11), 5'(i), 5'(7 - i)} ||
                sb.size() != 1 || {rs_data, rt_data} !== {sb[0].rs_d, sb[0].rt_d}) begin
                tests_failed++;
                bad++;
                $display("FAIL b2b_%0d: got rdy=%b v=%b rs=%h rt=%h ri=%0d ti=%0d, want rdy=1 v=1 rs=%h rt=%h",
                         i, pre_in_ready, out_valid, rs_data, rt_data, rs_idx, rt_idx,
                         32'(i * 32'h11), 32'((7 - i) * 32'h11));
            end
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_stalled();
        cycle(1'b1, 5'd9, 5'd10, 1'b1, 1'b0, 32'd0, '0, 1'b0);
        cycle(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 32'd0, '0, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, 32'h99, 32'hAA}) begin
            tests_failed++;
            $display("FAIL reset_stall_pre: got v=%0b rs=%h rt=%h, want 1 99 aa",
                     out_valid, rs_data, rt_data);
        end
        cycle(1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 32'd0, '0, 1'b1);
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_idx, rt_idx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_stall: got v=%0b rs=%h rt=%h ri=%0d ti=%0d, want all 0",
                     out_valid, rs_data, rt_data, rs_idx, rt_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_r0();
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        exp_a = ZERO_R0 ? 32'h0 : 32'hAA;
        exp_b = ZERO_R0 ? 32'h0 : 32'hBB;
        Q_all[0 +: WIDTH] = 32'hFFFF;
        cycle(1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 32'h1, 32'hAA, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, exp_a, 32'h11}) begin
            tests_failed++;
            $display("FAIL r0_bypass: got v=%0b rs=%h rt=%h, want 1 %h 11",
                     out_valid, rs_data, rt_data, exp_a);
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h1, 32'hBB, 1'b0);
        tests_run++;
        if ({out_valid, rs_data, rt_data} !== {1'b1, exp_b, 32'h11}) begin
            tests_failed++;
            $display("FAIL r0_stall: got v=%0b rs=%h rt=%h, want 1 %h 11",
                     out_valid, rs_data, rt_data, exp_b);
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; RegWriteI = 1'b0;
        CP_o = '0; Rd = '0; rs_addr = '0; rt_addr = '0;
        for (int i = 0; i < 32; i++) Q_all[i*WIDTH +: WIDTH] = 32'(i * 32'h11);
        test_reset();
        test_basic_read();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_reset_stalled();
        test_r0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
# regfile_read_stage

- Registered dual read port for the 32-entry register file.
- Selects two source operands from the file's 32 register outputs and applies same-cycle write bypass from the write port's one-hot enable.
- Holds the result in a single pipeline slot with valid/ready handshake, and keeps a stalled result coherent with later writes.
- Sits directly downstream of the register file and feeds the execute stage.

## Interface
- `WIDTH`, 32, data width of each register and each operand.
- `clk`  input  1  — single clock; all state updates on rising edge.
- `reset`  input  1  — synchronous, active-high; sampled on rising edge of `clk`.
- `Q_all`  input  32*WIDTH  — concatenated register-file outputs; register i at bits [i*WIDTH +: WIDTH] (register 0 = lowest slice).
- `RegWriteI`  input  1  — write-port global enable, same signal that drives the register file.
- `CP_o`  input  32  — write-port one-hot select, same signal that drives the register file.
- `Rd`  input  WIDTH  — write data presented to the register file this cycle.
- `in_valid`  input  1  — read request valid.
- `in_ready`  output  1  — stage can accept a request this cycle.
- `rs_addr`, `rt_addr`  input  5 each  — source register indices.
- `out_valid`  output  1  — operand pair valid.
- `out_ready`  input  1  — consumer accepts operand pair.
- `rs_data`, `rt_data`  output  WIDTH each  — registered operands.
- `rs_idx`, `rt_idx`  output  5 each  — registered copies of the accepted addresses.

## Operation
- Write hit for address a: `hit(a) = RegWriteI & CP_o[a]`. `CP_o` is used bitwise; no decode, no one-hot check.
- Operand select for address a: `hit(a) ? Rd : Q_all[a*WIDTH +: WIDTH]`.
- `in_ready = !out_valid || out_ready` (combinational; a full slot drains and refills in the same cycle).
- Accept (`in_valid && in_ready`):
  - `rs_data`/`rt_data` load the bypassed selections.
  - `rs_idx`/`rt_idx` load the addresses.
  - `out_valid` <= 1.
- Drain without accept (`out_valid && out_ready && !(in_valid && in_ready)`): `out_valid` <= 0; data/idx registers hold their values (don't-care).
- Stall (`out_valid && !out_ready`):
  - If `hit(rs_idx)`, `rs_data` <= `Rd`; if `hit(rt_idx)`, `rt_data` <= `Rd`. Otherwise both hold.
  - `rs_idx`/`rt_idx` hold.
  - The held pair therefore always equals the current register-file contents.
- `rs_addr == rt_addr` is legal; both outputs carry the same value.
- States: EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on stall, or on drain with accept.

## Timing
- Latency: a request accepted at edge N presents operands with `out_valid` = 1 after edge N.
- Throughput: one pair per cycle while `out_ready` = 1.
- Bypass is same-cycle: a write whose enable is active at edge N is visible in operands captured at edge N.
- Reset (any cycle, including mid-stall) clears `out_valid`, `rs_data`, `rt_data`, `rs_idx` and `rt_idx` to 0, so `in_ready` = 1 after reset. A request presented in the reset cycle is dropped.
- Handshake rules:
  - `out_valid`, data and idx are stable while `out_valid && !out_ready`, except for the stall write-update above.
  - `in_valid` is not required to be held; a non-accepted request is simply not captured.
- No combinational path from `in_valid` to `out_valid`. `in_ready` depends only on `out_valid` and `out_ready`.

## Configuration
- `REGREAD_ZERO_R0_EN` defined:
  - Address 0 reads as 0 regardless of `Q_all[WIDTH-1:0]`.
  - `hit(0)` is forced 0, so there is no bypass and no stall update for register 0.
- Not defined: register 0 behaves like any other register (select, bypass and stall update as above).

## Test plan
- Reset, then `Q_all` with register i = i*0x11, `rs_addr` = 3, `rt_addr` = 31, `in_valid` = 1, `out_ready` = 1 -> one edge later `out_valid` = 1, `rs_data` = 0x33, `rt_data` = 0x20F, `rs_idx` = 3, `rt_idx` = 31.
- Same-cycle bypass: request `rs_addr` = 5, `rt_addr` = 6 with `RegWriteI` = 1, `CP_o` = 0x20, `Rd` = 0xDEADBEEF -> `rs_data` = 0xDEADBEEF, `rt_data` = register 6 value. Repeat with `RegWriteI` = 0 -> `rs_data` = register 5 value.
- Stall update: capture `rs` = 7 and `rt` = 7 with value 0x77, hold `out_ready` = 0, write `CP_o` = 0x80, `Rd` = 0x1234 -> both outputs become 0x1234 next edge, `in_ready` = 0, and a new request is not captured. Release `out_ready` -> pair drains once.
- Back-to-back: `in_valid` = `out_ready` = 1 for 8 cycles with addresses 0..7 -> 8 consecutive valid pairs, no bubbles, `in_ready` = 1 throughout.
- Reset while FULL and stalled -> after the edge `out_valid` = 0 and all data/idx = 0. With `REGREAD_ZERO_R0_EN` defined: `rs_addr` = 0, register 0 = 0xFFFF, write `CP_o` = 0x1, `Rd` = 0xAA -> `rs_data` = 0. Without the macro -> `rs_data` = 0xAA.
